// File: rtl/uart_rx_ext_if.sv
// Serial-in / word-out signal bundle for uart_rx_ext.
// slave = the receiver, master = line driver plus word consumer.
interface uart_rx_ext_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  RxD;
    logic [DATA_WIDTH-1:0] RxData;
    logic                  valid_rx;
    logic                  parity_err;
    logic                  frame_err;
    logic                  break_det;
    logic                  busy;

    modport master (
        output RxD,
        input  RxData, valid_rx, parity_err, frame_err, break_det, busy
    );

    modport slave (
        input  RxD,
        output RxData, valid_rx, parity_err, frame_err, break_det, busy
    );
endinterface

// File: rtl/uart_rx_ext.sv
// Oversampling UART receiver with configurable frame format, 3-sample majority vote,
// and parity / framing / break detection.
module uart_rx_ext #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CLK_FREQ   = 1_600_000,
    parameter int unsigned BAUD_RATE  = 10_000,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input logic          clk,
    input logic          reset,
    uart_rx_ext_if.slave rx
);
    localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned TW      = $clog2(OVERSAMPLE);
    localparam int unsigned BW      = $clog2(DATA_WIDTH);

    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
    localparam logic [TW-1:0] T_LAST   = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] T_S0     = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_S1     = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_DEC    = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic          ODD_PAR  = (PARITY == 2);

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK
    } state_t;

    state_t                state_q;
    logic                  sync1_q, sync2_q, prev_q, armed_q;
    logic [CW-1:0]         div_q;
    logic [TW-1:0]         tcnt_q, tcnt_d;
    logic [BW-1:0]         bitn_q;
    logic                  stopn_q;
    logic                  v0_q, v1_q;
    logic [DATA_WIDTH-1:0] sh_q, data_q;
    logic                  par_q, zero_q, perr_pend_q, ferr_acc_q, brk_pend_q;
    logic                  valid_q, perr_q, ferr_q, brk_q, busy_q;
    logic                  rxs, tick, decide, vote, fall, ferr_now, brk_now;

    assign rxs = sync2_q;

    always_comb begin
        tick     = (div_q == DIV_LAST);
        tcnt_d   = (tcnt_q == T_LAST) ? '0 : tcnt_q + 1'b1;
        decide   = tick && (tcnt_d == T_DEC);
        vote     = (v0_q & v1_q) | (v0_q & rxs) | (v1_q & rxs);
        fall     = armed_q & prev_q & ~rxs;
        ferr_now = ferr_acc_q | ~vote;
        brk_now  = (stopn_q == 1'b0) ? (zero_q & ~vote) : brk_pend_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b0;
            armed_q     <= 1'b0;
            div_q       <= '0;
            tcnt_q      <= '0;
            bitn_q      <= '0;
            stopn_q     <= 1'b0;
            v0_q        <= 1'b1;
            v1_q        <= 1'b1;
            sh_q        <= '0;
            par_q       <= 1'b0;
            zero_q      <= 1'b0;
            perr_pend_q <= 1'b0;
            ferr_acc_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            brk_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sync1_q <= rx.RxD;
            sync2_q <= sync1_q;
            prev_q  <= rxs;
            // Arm only once the whole synchroniser pipe shows high, so the
            // reset value of the flops cannot fake an idle line.
            if (rxs && prev_q && sync1_q) armed_q <= 1'b1;
            valid_q <= 1'b0;
            div_q   <= tick ? '0 : div_q + 1'b1;
            if (tick) tcnt_q <= tcnt_d;
            if (tick && tcnt_d == T_S0) v0_q <= rxs;
            if (tick && tcnt_d == T_S1) v1_q <= rxs;

            case (state_q)
                ST_IDLE: begin
                    busy_q <= 1'b0;
                    if (fall) begin
                        state_q     <= ST_START;
                        busy_q      <= 1'b1;
                        armed_q     <= 1'b0;
                        div_q       <= '0;
                        tcnt_q      <= '0;
                        bitn_q      <= '0;
                        stopn_q     <= 1'b0;
                        par_q       <= 1'b0;
                        zero_q      <= 1'b1;
                        perr_pend_q <= 1'b0;
                        ferr_acc_q  <= 1'b0;
                        brk_pend_q  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (decide) begin
                        if (vote) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (decide) begin
                        sh_q   <= {vote, sh_q[DATA_WIDTH-1:1]};
                        par_q  <= par_q ^ vote;
                        zero_q <= zero_q & ~vote;
                        bitn_q <= bitn_q + 1'b1;
                        if (bitn_q == BIT_LAST)
                            state_q <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    if (decide) begin
                        perr_pend_q <= vote ^ par_q ^ ODD_PAR;
                        zero_q      <= zero_q & ~vote;
                        state_q     <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (decide) begin
                        if (stopn_q == STOP_LAST) begin
                            data_q  <= sh_q;
                            perr_q  <= perr_pend_q;
                            ferr_q  <= ferr_now;
                            brk_q   <= brk_now;
                            valid_q <= 1'b1;
                            if (brk_now) begin
                                state_q <= ST_BREAK;
                            end else begin
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                                armed_q <= 1'b0;
                            end
                        end else begin
                            stopn_q    <= 1'b1;
                            ferr_acc_q <= ferr_now;
                            brk_pend_q <= brk_now;
                        end
                    end
                end
                ST_BREAK: begin
                    if (rxs) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rx.RxData     = data_q;
    assign rx.valid_rx   = valid_q;
    assign rx.parity_err = perr_q;
    assign rx.frame_err  = ferr_q;
    assign rx.break_det  = brk_q;
    assign rx.busy       = busy_q;
endmodule
